transfer_write_arbiter: RTL and testbench

//  Round-robin write arbiter/sequencer for the register bank built from transfer_or gates.

---
 rtl/transfer_write_arbiter.sv | 109 ++++++++++
 tb/tb_transfer_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_write_arbiter.sv
// rtl/transfer_write_arbiter.sv - round-robin write sequencer for a transfer_or register bank
// One grant per two-cycle write slot; drives one-hot transfer-gate selects and shared write data.
module transfer_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_REG  = 4,
  parameter int AW     = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    freeze,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REG-1:0]        sel,
  output logic [DATA_W-1:0]       wdata,
  output logic                    busy,
  output logic                    err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       ptr, ptr_nx;
  logic [PW-1:0]       win, win_nx;
  logic [N_REQ-1:0]    grant_nx;
  logic [N_REG-1:0]    sel_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic                busy_nx, err_nx;

  logic                found;
  logic [PW-1:0]       pick;
  logic [AW-1:0]       pick_addr;
  logic [DATA_W-1:0]   pick_data;
  int                  idx;

  // Scan starts at the rr pointer and wraps, so the first hit is the fair winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    pick_addr = req_addr[int'(pick)*AW +: AW];
    pick_data = req_data[int'(pick)*DATA_W +: DATA_W];
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    win_nx   = win;
    grant_nx = '0;
    sel_nx   = '0;
    wdata_nx = '0;
    busy_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !freeze) begin
          state_nx = WRITE;
          win_nx   = pick;
          grant_nx = N_REQ'(1) << pick;
          wdata_nx = pick_data;
          busy_nx  = 1'b1;
          // Out-of-range address still gets its grant, but no gate is selected.
          if (int'(pick_addr) < N_REG) sel_nx = N_REG'(1) << pick_addr;
          else                         err_nx = 1'b1;
        end
      end
      WRITE: begin
        state_nx = IDLE;
        ptr_nx   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      grant <= '0;
      sel   <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      win   <= win_nx;
      grant <= grant_nx;
      sel   <= sel_nx;
      wdata <= wdata_nx;
      busy  <= busy_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_transfer_write_arbiter.sv
// tb/tb_transfer_write_arbiter.sv - scoreboard bench for transfer_write_arbiter
// Two instances (N_REG=4 and N_REG=3) share stimulus so out-of-range writes are exercised.
module tb_transfer_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        freeze = 1'b0;

  logic [3:0] grant4, sel4, grant3;
  logic [2:0] sel3;
  logic [7:0] wdata4, wdata3;
  logic       busy4, busy3, err4, err3;

  always #5 clk = ~clk;

  transfer_write_arbiter #(.N_REQ(4), .N_REG(4), .AW(2), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .freeze(freeze), .grant(grant4), .sel(sel4), .wdata(wdata4), .busy(busy4), .err(err4));

  transfer_write_arbiter #(.N_REQ(4), .N_REG(3), .AW(2), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .freeze(freeze), .grant(grant3), .sel(sel3), .wdata(wdata3), .busy(busy3), .err(err3));

  logic [7:0] bank4 [4] = '{default: 8'h00};
  logic [7:0] bank3 [3] = '{default: 8'h00};

  // Bank of transfer_or registers: load wdata when selected, else hold.
  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) if (sel4[r]) bank4[r] <= wdata4;
    for (int r = 0; r < 3; r++) if (sel3[r]) bank3[r] <= wdata3;
  end

  typedef struct {
    logic [3:0] g;
    logic [3:0] s4;
    logic [2:0] s3;
    logic [7:0] d;
    logic       e4;
    logic       e3;
  } exp_t;

  exp_t       q[$];
  int         gcyc[$];
  int         cyc = 0;
  int         remaining[4] = '{default: 0};
  logic [3:0] g_seen = '0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_w(input int i, input int a, input logic [7:0] d);
    exp_t e;
    e.g  = 4'(1 << i);
    e.s4 = 4'(1 << a);
    e.s3 = (a < 3) ? 3'(1 << a) : 3'b000;
    e.d  = d;
    e.e4 = 1'b0;
    e.e3 = (a >= 3);
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input int a, input logic [7:0] d, input int n);
    req_addr[i*2 +: 2] = 2'(a);
    req_data[i*8 +: 8] = d;
    remaining[i]       = n;
    req[i]             = 1'b1;
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      g_seen = grant4;
      if (busy4) begin
        gcyc.push_back(cyc);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: grant=%b sel=%b with empty scoreboard (cycle %0d)", grant4, sel4, cyc);
        end else begin
          e = q.pop_front();
          chk("grant4", grant4, e.g);
          chk("sel4",   sel4,   e.s4);
          chk("wdata4", wdata4, e.d);
          chk("err4",   err4,   e.e4);
          chk("busy3",  busy3,  1);
          chk("grant3", grant3, e.g);
          chk("sel3",   sel3,   e.s3);
          chk("wdata3", wdata3, e.d);
          chk("err3",   err3,   e.e3);
        end
      end else begin
        chk("idle_out4", {grant4, sel4, wdata4, err4}, 0);
        chk("idle_out3", {busy3, grant3, sel3, wdata3, err3}, 0);
      end
    end
  endtask

  // Requester side: drop req on the edge that ends its last needed grant.
  task automatic driver_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (g_seen[i]) begin
          remaining[i]--;
          if (remaining[i] <= 0) req[i] = 1'b0;
        end
      end
      g_seen = '0;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((req != 0 || busy4 || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: req=%b busy=%b pending=%0d", name, req, busy4, q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] snap3 [3];

  initial begin
    fork
      monitor_loop();
      driver_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out4", {busy4, grant4, sel4, wdata4, err4}, 0);
    chk("rst_out3", {busy3, grant3, sel3, wdata3, err3}, 0);
    rst = 1'b0;

    // 1: single request, register 3 <- A5, one-cycle latency
    @(negedge clk);
    set_req(2, 3, 8'hA5, 1);
    expect_w(2, 3, 8'hA5);
    @(negedge clk);
    chk("t1_latency_busy", busy4, 1);
    wait_done("t1");
    chk("t1_bank4_r3", bank4[3], 8'hA5);

    // 2: all four held from ptr=0, one grant every 2 cycles
    do_reset();
    gcyc.delete();
    for (int i = 0; i < 4; i++) set_req(i, i, 8'h10 + 8'(i), (i == 0) ? 2 : 1);
    expect_w(0, 0, 8'h10);
    expect_w(1, 1, 8'h11);
    expect_w(2, 2, 8'h12);
    expect_w(3, 3, 8'h13);
    expect_w(0, 0, 8'h10);
    wait_done("t2");
    chk("t2_grant_count", gcyc.size(), 5);
    if (gcyc.size() == 5)
      for (int k = 1; k < 5; k++) chk("t2_slot_spacing", gcyc[k] - gcyc[k-1], 2);

    // 3: move ptr to 3, then req0 and req3 collide on register 1
    set_req(2, 2, 8'h22, 1);
    expect_w(2, 2, 8'h22);
    wait_done("t3_prep");
    set_req(0, 1, 8'h11, 1);
    set_req(3, 1, 8'h33, 1);
    expect_w(3, 1, 8'h33);
    expect_w(0, 1, 8'h11);
    wait_done("t3");
    chk("t3_bank4_r1", bank4[1], 8'h11);

    // 4: freeze blocks the start; release grants one cycle later
    freeze = 1'b1;
    set_req(1, 0, 8'h44, 1);
    repeat (10) @(negedge clk);
    chk("t4_frozen_grant", grant4, 0);
    expect_w(1, 0, 8'h44);
    freeze = 1'b0;
    @(negedge clk);
    chk("t4_release_grant", grant4, 4'b0010);
    wait_done("t4");
    chk("t4_bank4_r0", bank4[0], 8'h44);

    // 5: address 3 is out of range for the N_REG=3 bank
    for (int r = 0; r < 3; r++) snap3[r] = bank3[r];
    set_req(1, 3, 8'hFF, 1);
    expect_w(1, 3, 8'hFF);
    wait_done("t5");
    for (int r = 0; r < 3; r++) chk("t5_bank3_unchanged", bank3[r], snap3[r]);
    chk("t5_bank4_r3", bank4[3], 8'hFF);

    // 6: reset in the WRITE cycle still commits; afterwards ptr scans from 0
    set_req(2, 0, 8'h5A, 1);
    expect_w(2, 0, 8'h5A);
    begin
      int n = 0;
      while (!busy4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t6_write_seen", busy4, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_out4", {busy4, grant4, sel4, wdata4, err4}, 0);
    chk("t6_commit_r0", bank4[0], 8'h5A);
    rst = 1'b0;
    set_req(2, 1, 8'h62, 1);
    set_req(3, 2, 8'h73, 1);
    expect_w(2, 1, 8'h62);
    expect_w(3, 2, 8'h73);
    wait_done("t6");
    chk("t6_bank4_r1", bank4[1], 8'h62);
    chk("t6_bank4_r2", bank4[2], 8'h73);

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
